// File: rtl/rotator_pkg.sv
// Shared encodings for the iterative rotator: FSM states and direction values.
package rotator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ROT  = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam logic LEFT  = 1'b1;
  localparam logic RIGHT = 1'b0;

endpackage

// File: rtl/rot1_lr.sv
// Combinational single-position rotator.
// Left moves the MSB into the LSB; right moves the LSB into the MSB.
module rot1_lr
  import rotator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  logic             lr,
  output logic [WIDTH-1:0] q
);

  // One-step rotate in the requested direction
  always_comb begin
    q = {d[0], d[WIDTH-1:1]};
    if (lr == LEFT) q = {d[WIDTH-2:0], d[WIDTH-1]};
  end

endmodule

// File: rtl/seq_rotator_lr.sv
// Iterative valid/ready rotator: one bit position per clock.
// The operand is captured on accept, rotated amt times by a single-step
// rotator, then held until the consumer takes it.
module seq_rotator_lr
  import rotator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             lr,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic [WIDTH-1:0] rot_step;

  // Single-step rotation of the working register
  rot1_lr #(.WIDTH(WIDTH)) u_rot1 (
    .d  (data_q),
    .lr (dir_q),
    .q  (rot_step)
  );

  assign in_ready  = (state_q == IDLE) & ~reset;
  assign out_valid = (state_q == HOLD);
  assign y         = data_q;

  // Next-state logic: capture on accept, step while counting down, hold for hand-off.
  // cnt_q counts the remaining steps; amt >= WIDTH simply takes more steps,
  // which yields the mod-WIDTH result without any wrap in the counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = a;
          dir_d   = lr;
          cnt_d   = amt;
          state_d = (amt == '0) ? HOLD : ROT;
        end
      end
      ROT: begin
        data_d = rot_step;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= RIGHT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_seq_rotator_lr.sv
// Scoreboard bench for seq_rotator_lr at WIDTH=8 (directed + random)
// and WIDTH=5 (random, covering amt >= WIDTH).
module tb_seq_rotator_lr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       rst8, iv8, rdy8, lr8, ov8, ordy8;
  logic [7:0] a8, y8;
  logic [2:0] amt8;

  seq_rotator_lr #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(rdy8), .a(a8), .lr(lr8),
    .amt(amt8), .out_valid(ov8), .out_ready(ordy8), .y(y8)
  );

  // WIDTH=5 instance
  logic       rst5, iv5, rdy5, lr5, ov5, ordy5;
  logic [4:0] a5, y5;
  logic [2:0] amt5;

  seq_rotator_lr #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(rst5), .in_valid(iv5), .in_ready(rdy5), .a(a5), .lr(lr5),
    .amt(amt5), .out_valid(ov5), .out_ready(ordy5), .y(y5)
  );

  logic [7:0] q8[$];
  logic [4:0] q5[$];

  // Reference: rotate by (amt mod w) using plain shifts on a w-bit value
  function automatic logic [31:0] rot_ref(input logic [31:0] v, input logic left,
                                          input int amt, input int w);
    int n;
    logic [31:0] m;
    m = (32'h1 << w) - 32'h1;
    v = v & m;
    n = amt % w;
    if (n == 0) return v;
    if (left) return ((v << n) | (v >> (w - n))) & m;
    return ((v >> n) | (v << (w - n))) & m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitors: a hand-off happens at the next posedge when out_valid & out_ready
  always @(negedge clk) begin
    #1;
    if (ov8 === 1'b1 && ordy8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb8_unexpected: got y=%0h expected no output at %0t", y8, $time);
      end else begin
        chk("sb8_y", 32'(y8), 32'(q8.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (ov5 === 1'b1 && ordy5 === 1'b1) begin
      if (q5.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb5_unexpected: got y=%0h expected no output at %0t", y5, $time);
      end else begin
        chk("sb5_y", 32'(y5), 32'(q5.pop_front()));
      end
    end
  end

  // Directed transfer on the WIDTH=8 instance with latency and value checks
  task automatic op8(input logic [7:0] av, input logic l, input logic [2:0] m,
                     input logic [7:0] ey, input string nm);
    int t = 0;
    int lat = 0;
    @(negedge clk);
    while (!rdy8 && t < 50) begin @(negedge clk); t++; end
    chk({nm, "_ready"}, 32'(rdy8), 32'd1);
    a8 = av; lr8 = l; amt8 = m; iv8 = 1'b1;
    q8.push_back(8'(rot_ref(32'(av), l, int'(m), 8)));
    @(negedge clk);
    // scramble operands after accept: must have no effect
    iv8 = 1'b0; a8 = 8'($urandom); lr8 = 1'($urandom); amt8 = 3'($urandom);
    chk({nm, "_busy"}, 32'(rdy8), 32'd0);
    while (!ov8 && lat < 50) begin @(negedge clk); lat++; end
    chk({nm, "_lat"}, 32'(lat), 32'(m));
    chk({nm, "_y"}, 32'(y8), 32'(ey));
  endtask

  task automatic rand8(input int n);
    int sent = 0;
    int guard = 0;
    bit pend = 0;
    while (sent < n && guard < 60000) begin
      @(negedge clk); guard++;
      ordy8 = ($urandom_range(0, 3) != 0);
      if (pend) begin iv8 = 1'b0; pend = 0; end
      if (!iv8) begin
        a8 = 8'($urandom); lr8 = 1'($urandom); amt8 = 3'($urandom);
        if ($urandom_range(0, 2) != 0) iv8 = 1'b1;
      end
      if (iv8 && rdy8) begin
        q8.push_back(8'(rot_ref(32'(a8), lr8, int'(amt8), 8)));
        sent++; pend = 1;
      end
    end
    chk("rand8_sent", 32'(sent), 32'(n));
    @(negedge clk); iv8 = 1'b0; ordy8 = 1'b1;
  endtask

  task automatic rand5(input int n);
    int sent = 0;
    int guard = 0;
    bit pend = 0;
    while (sent < n && guard < 60000) begin
      @(negedge clk); guard++;
      ordy5 = ($urandom_range(0, 3) != 0);
      if (pend) begin iv5 = 1'b0; pend = 0; end
      if (!iv5) begin
        a5 = 5'($urandom); lr5 = 1'($urandom); amt5 = 3'($urandom);
        if ($urandom_range(0, 2) != 0) iv5 = 1'b1;
      end
      if (iv5 && rdy5) begin
        q5.push_back(5'(rot_ref(32'(a5), lr5, int'(amt5), 5)));
        sent++; pend = 1;
      end
    end
    chk("rand5_sent", 32'(sent), 32'(n));
    @(negedge clk); iv5 = 1'b0; ordy5 = 1'b1;
  endtask

  initial begin
    logic [7:0] yh;
    int t;
    rst8 = 1'b1; iv8 = 1'b0; a8 = '0; lr8 = 1'b0; amt8 = '0; ordy8 = 1'b1;
    rst5 = 1'b1; iv5 = 1'b0; a5 = '0; lr5 = 1'b0; amt5 = '0; ordy5 = 1'b1;
    #1;
    chk("rst_y", 32'(y8), 32'd0);
    chk("rst_ov", 32'(ov8), 32'd0);
    chk("rst_rdy", 32'(rdy8), 32'd0);
    chk("rst5_rdy", 32'(rdy5), 32'd0);
    repeat (3) @(negedge clk);
    rst8 = 1'b0; rst5 = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(rdy8), 32'd1);

    // Basic, multi-step right, zero and maximum amounts
    op8(8'h81, 1'b1, 3'd1, 8'h03, "left1");
    op8(8'hB4, 1'b0, 3'd3, 8'h96, "right3");
    op8(8'h5A, 1'b1, 3'd0, 8'h5A, "zero");
    op8(8'h01, 1'b1, 3'd7, 8'h80, "max");
    @(negedge clk);
    chk("single_pulse_ov", 32'(ov8), 32'd0);

    // Backpressure: result must stay frozen while the consumer stalls
    ordy8 = 1'b0;
    op8(8'hC5, 1'b0, 3'd2, 8'h71, "bp");
    yh = y8;
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'($urandom); a8 = 8'($urandom); lr8 = 1'($urandom); amt8 = 3'($urandom);
      @(negedge clk);
      chk("bp_y", 32'(y8), 32'(yh));
      chk("bp_ov", 32'(ov8), 32'd1);
      chk("bp_rdy", 32'(rdy8), 32'd0);
    end
    iv8 = 1'b0; ordy8 = 1'b1;
    @(negedge clk);
    chk("bp_exit_rdy", 32'(rdy8), 32'd1);
    chk("bp_exit_ov", 32'(ov8), 32'd0);

    // Reset in the middle of a rotation discards the result
    t = 0;
    while (!rdy8 && t < 50) begin @(negedge clk); t++; end
    a8 = 8'hC3; lr8 = 1'b0; amt8 = 3'd6; iv8 = 1'b1;
    @(negedge clk); iv8 = 1'b0;
    @(negedge clk);
    rst8 = 1'b1;
    #1;
    chk("mid_rst_y", 32'(y8), 32'd0);
    chk("mid_rst_ov", 32'(ov8), 32'd0);
    chk("mid_rst_rdy", 32'(rdy8), 32'd0);
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    chk("after_rst_rdy", 32'(rdy8), 32'd1);
    chk("after_rst_ov", 32'(ov8), 32'd0);
    op8(8'h96, 1'b1, 3'd5, 8'hD2, "after_rst");

    // Random regression on both widths in parallel
    fork
      rand8(2000);
      rand5(2000);
    join

    t = 0;
    while ((q8.size() != 0 || q5.size() != 0) && t < 200) begin @(negedge clk); t++; end
    chk("drain8", 32'(q8.size()), 32'd0);
    chk("drain5", 32'(q5.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
